// File: rtl/i2s_transmitter.sv
// I2S bus-master transmitter: divides clk into i2s_sck/i2s_ws and shifts stereo
// PCM frames out MSB-first with the one-bit I2S data delay.
module i2s_transmitter #(
    parameter int DATA_SIZE = 16,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] left_data,
    input  logic [DATA_SIZE-1:0] right_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 i2s_sck,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun
);

    localparam int FRAME  = 2 * DATA_SIZE;
    localparam int SLOT_W = $clog2(FRAME);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(DATA_SIZE);

    logic [DIV_W-1:0]     div_cnt;
    logic [SLOT_W-1:0]    slot;
    logic [SLOT_W-1:0]    slot_nxt;
    logic [FRAME-1:0]     shift_reg;
    logic [DATA_SIZE-1:0] hold_left;
    logic [DATA_SIZE-1:0] hold_right;
    logic                 full;
    logic                 tick;
    logic                 fall;
    logic                 frame_start;
    logic                 accept;

    assign sample_ready = ~full;
    assign tick         = (div_cnt == DIV_LAST);
    assign fall         = tick & i2s_sck;
    assign frame_start  = fall & (slot == SLOT_LAST);
    assign accept       = sample_valid & ~full;

    always_comb begin
        slot_nxt = slot + 1'b1;
        if (slot == SLOT_LAST)
            slot_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            i2s_sck    <= 1'b0;
            i2s_ws     <= 1'b1;
            i2s_sd     <= 1'b0;
            underrun   <= 1'b0;
            slot       <= SLOT_LAST;
            shift_reg  <= '0;
            hold_left  <= '0;
            hold_right <= '0;
            full       <= 1'b0;
        end else begin
            underrun <= 1'b0;
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                i2s_sck <= ~i2s_sck;

            // accept and frame-start drain are disjoint: one needs full low, the other high
            if (accept) begin
                hold_left  <= left_data;
                hold_right <= right_data;
                full       <= 1'b1;
            end

            if (fall) begin
                slot   <= slot_nxt;
                i2s_ws <= (slot_nxt >= SLOT_HALF);
                // MSB of the shifter is always the bit for the upcoming slot, which
                // yields the one-slot delay and carries the right LSB into slot 0
                i2s_sd <= shift_reg[FRAME-1];
                if (frame_start) begin
                    if (full) begin
                        shift_reg <= {hold_left, hold_right};
                        full      <= 1'b0;
                    end else begin
                        shift_reg <= '0;
                        underrun  <= 1'b1;
                    end
                end else begin
                    shift_reg <= {shift_reg[FRAME-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter (DATA_SIZE=16, CLK_DIV=2): stimulus pushes the
// expected frame contents, a bus monitor reassembles i2s_sd/i2s_ws and compares.
module tb_i2s_transmitter;

    localparam int DS   = 16;
    localparam int DIV  = 2;
    localparam int FPER = 2 * DS * 2 * DIV;

    typedef struct {
        logic [2*DS-1:0] word;
        bit              und;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DS-1:0] left_data;
    logic [DS-1:0] right_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          i2s_sck;
    logic          i2s_ws;
    logic          i2s_sd;
    logic          underrun;

    i2s_transmitter #(.DATA_SIZE(DS), .CLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int              cyc = 0;
    bit              m_full = 0;
    logic [2*DS-1:0] m_word = '0;
    bit              last_acc = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // one clock: expectation model from the bench's own frame-start timing
    task automatic step();
        bit fs;
        bit acc;
        @(posedge clk);
        acc = 1'b0;
        if (!rst) begin
            cyc++;
            fs  = (cyc >= 2 * DIV) && (((cyc - 2 * DIV) % FPER) == 0);
            acc = sample_valid && !m_full;
            if (fs) begin
                if (m_full) begin
                    sb.push_back('{m_word, 1'b0});
                    m_full = 0;
                end else begin
                    sb.push_back('{'0, 1'b1});
                end
            end
            if (acc) begin
                m_word = {left_data, right_data};
                m_full = 1;
            end
        end
        last_acc = acc;
        #1;
        chk(sample_ready == !m_full, "sample_ready", 64'(sample_ready), 64'(!m_full));
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic offer(input logic [DS-1:0] l, input logic [DS-1:0] r);
        int budget;
        left_data    = l;
        right_data   = r;
        sample_valid = 1'b1;
        budget       = 2 * FPER;
        do begin
            step();
            budget--;
        end while (!last_acc && budget > 0);
        if (!last_acc)
            chk(1'b0, "accept_timeout", 64'(0), 64'(1));
        sample_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        logic [4:0] v;
        v = {i2s_sck, i2s_ws, i2s_sd, sample_ready, underrun};
        chk(v == 5'b01010, "reset_values", 64'(v), 64'(5'b01010));
    endtask

    task automatic check_restart_sck();
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            step();
            p = {p[2:0], i2s_sck};
        end
        chk(p == 4'b0110, "sck_start_edges", 64'(p), 64'(4'b0110));
    endtask

    // bus monitor
    bit              prev_sck = 0;
    bit              started = 0;
    int              mslot = 0;
    bit              cur_valid = 0;
    bit              have_prev = 0;
    exp_t            cur;
    exp_t            prev;
    logic [2*DS-1:0] acc_word = '0;
    logic [2*DS-1:0] ws_vec = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_sck  = 0;
            started   = 0;
            cur_valid = 0;
            have_prev = 0;
        end else begin
            if (prev_sck && !i2s_sck) begin
                if (!started) begin
                    started = 1;
                    mslot   = 0;
                end else begin
                    mslot = (mslot == 2 * DS - 1) ? 0 : mslot + 1;
                end
                if (mslot == 0) begin
                    if (cur_valid) begin
                        prev      = cur;
                        have_prev = 1;
                    end
                    if (sb.size() == 0) begin
                        chk(1'b0, "scoreboard_empty", 64'(0), 64'(1));
                        cur_valid = 0;
                    end else begin
                        cur       = sb.pop_front();
                        cur_valid = 1;
                        chk(underrun == cur.und, "underrun_at_frame_start", 64'(underrun), 64'(cur.und));
                    end
                end else if (underrun) begin
                    chk(1'b0, "spurious_underrun", 64'(1), 64'(0));
                end
            end else if (underrun) begin
                chk(1'b0, "spurious_underrun", 64'(1), 64'(0));
            end

            if (!prev_sck && i2s_sck && started) begin
                ws_vec[mslot] = i2s_ws;
                if (mslot == 0) begin
                    if (have_prev) begin
                        chk({acc_word[2*DS-2:0], i2s_sd} == prev.word, "frame_data",
                            64'({acc_word[2*DS-2:0], i2s_sd}), 64'(prev.word));
                        have_prev = 0;
                    end else begin
                        chk(i2s_sd == 1'b0, "slot0_sd_after_reset", 64'(i2s_sd), 64'(0));
                    end
                    acc_word = '0;
                end else begin
                    acc_word = {acc_word[2*DS-2:0], i2s_sd};
                end
                if (mslot == 2 * DS - 1)
                    chk(ws_vec == 32'hFFFF_0000, "ws_pattern", 64'(ws_vec), 64'(32'hFFFF_0000));
            end
            prev_sck = i2s_sck;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        left_data    = '0;
        right_data   = '0;
        repeat (3) step();
        check_reset_vals();
        rst = 1'b0;
        check_restart_sck();                  // frame at 4: underrun, zeros

        run_to(10);
        offer(16'hA5C3, 16'h5A3C);            // plays in frame at 132

        run_to(140);
        for (int n = 1; n <= 4; n++)          // back-to-back: frames 260..644
            offer(16'(n), 16'(16'h8000 + n));

        run_to(780);                          // frame 772 underruns
        offer(16'h0005, 16'h8005);            // plays at 900

        run_to(1027);                         // valid lands on frame-start edge 1028
        left_data    = 16'h1234;
        right_data   = 16'hFEDC;
        sample_valid = 1'b1;
        step();
        chk(last_acc, "collision_accept", 64'(last_acc), 64'(1));
        sample_valid = 1'b0;

        run_to(1160);
        offer(16'h0F0F, 16'hF0F0);            // plays at 1284
        run_to(1286);
        offer(16'hDEAD, 16'hBEEF);            // held, then dropped by reset

        run_to(1324);                         // slot 10 of frame 1284
        rst = 1'b1;
        sb.delete();
        m_full = 0;
        cyc    = 0;
        step();
        check_reset_vals();
        rst = 1'b0;
        check_restart_sck();                  // held pair must not play here

        run_to(10);
        offer(16'h8001, 16'h7FFE);
        run_to(270);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
